// File: rtl/spi_rf_gen2.sv
// -----------------------------------------------------------------------------
// spi_rf_gen2 -- APB register file for the SPI controller.
//
// Holds the control, slave-select, interrupt and frame-counter registers and
// turns SPI datapath strobes into latched interrupt sources. Reads are
// combinational from paddr and return 0 outside a decoded read.
//
// Optional feature: define SPI_RF_GEN2_TIMEOUT_EN to build the TOUT register,
// the RX idle-timeout counter and int_raw[5]. Without it 0x2C is unmapped and
// int_raw[5] / INTEN[5] read as 0.
// -----------------------------------------------------------------------------
module spi_rf_gen2 #(
    parameter int APB_DWIDTH = 8,
    parameter int NUM_SSEL   = 8,
    parameter int CNT_W      = 8
) (
    input  logic                  pclk,
    input  logic                  aresetn,
    input  logic                  sresetn,
    // APB slave
    input  logic [6:0]            paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_DWIDTH-1:0] pwdata,
    output logic [APB_DWIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  interrupt,
    // SPI datapath status and strobes
    input  logic                  tx_done,
    input  logic                  rx_done,
    input  logic                  rx_overflow,
    input  logic                  tx_underflow,
    input  logic                  rx_fifo_read,
    input  logic                  rx_fifo_empty,
    input  logic                  tx_fifo_full,
    input  logic                  active,
    // Configuration and control to the datapath
    output logic                  cfg_enable,
    output logic                  cfg_master,
    output logic [NUM_SSEL-1:0]   cfg_ssel,
    output logic                  clr_txfifo,
    output logic                  clr_rxfifo
);

    // -------------------------------------------------------------------------
    // Address map
    // -------------------------------------------------------------------------
    localparam logic [6:0] ADDR_CTRL    = 7'h00;
    localparam logic [6:0] ADDR_INTCLR  = 7'h04;
    localparam logic [6:0] ADDR_INTEN   = 7'h08;
    localparam logic [6:0] ADDR_INTMASK = 7'h10;
    localparam logic [6:0] ADDR_INTRAW  = 7'h14;
    localparam logic [6:0] ADDR_FRMTHR  = 7'h18;
    localparam logic [6:0] ADDR_CMD     = 7'h1C;
    localparam logic [6:0] ADDR_STATUS  = 7'h20;
    localparam logic [6:0] ADDR_SSEL    = 7'h24;
    localparam logic [6:0] ADDR_FRMCNT  = 7'h28;
    localparam logic [6:0] ADDR_TOUT    = 7'h2C;

`ifdef SPI_RF_GEN2_TIMEOUT_EN
    localparam logic [5:0] INT_IMPL = 6'h3F;
`else
    localparam logic [5:0] INT_IMPL = 6'h1F;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Register state
    // -------------------------------------------------------------------------
    logic [1:0]          ctrl_q,    ctrl_d;
    logic [5:0]          inten_q,   inten_d;
    logic [5:0]          int_raw_q, int_raw_d;
    logic [CNT_W-1:0]    frmthr_q,  frmthr_d;
    logic [CNT_W-1:0]    frmcnt_q,  frmcnt_d;
    logic [NUM_SSEL-1:0] ssel_q,    ssel_d;
    logic                clr_rx_q,  clr_rx_d;
    logic                clr_tx_q,  clr_tx_d;

    // Decode
    logic wr_en, rd_en, acc_en;
    logic addr_mapped;
    logic wr_ctrl, wr_intclr, wr_inten, wr_frmthr, wr_cmd, wr_ssel, wr_tout;

    // Event terms
    logic [CNT_W-1:0] frmcnt_inc;
    logic             frm_clr;
    logic             pkt_done;
    logic             tout_set;
    logic [5:0]       int_set;
    logic [5:0]       int_clr;

    logic [APB_DWIDTH-1:0] rdata;

    assign wr_en  = psel & pwrite & penable;
    assign rd_en  = psel & ~pwrite & penable;
    assign acc_en = psel & penable;

    // Decode paddr into a mapped flag and per-register write strobes.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        addr_mapped = 1'b1;
        wr_ctrl     = 1'b0;
        wr_intclr   = 1'b0;
        wr_inten    = 1'b0;
        wr_frmthr   = 1'b0;
        wr_cmd      = 1'b0;
        wr_ssel     = 1'b0;
        wr_tout     = 1'b0;
        case (paddr)
            ADDR_CTRL:    wr_ctrl   = wr_en;
            ADDR_INTCLR:  wr_intclr = wr_en;
            ADDR_INTEN:   wr_inten  = wr_en;
            ADDR_INTMASK: ;
            ADDR_INTRAW:  ;
            ADDR_FRMTHR:  wr_frmthr = wr_en;
            ADDR_CMD:     wr_cmd    = wr_en;
            ADDR_STATUS:  ;
            ADDR_SSEL:    wr_ssel   = wr_en;
            ADDR_FRMCNT:  ;
`ifdef SPI_RF_GEN2_TIMEOUT_EN
            ADDR_TOUT:    wr_tout   = wr_en;
`endif
            default:      addr_mapped = 1'b0;
        endcase
    end

    // An unmapped address only errors in the access phase; its write strobes
    // are already zero, so the access leaves all state untouched.
    assign pslverr = acc_en & ~addr_mapped;

    // -------------------------------------------------------------------------
    // Optional RX idle timeout
    // -------------------------------------------------------------------------
`ifdef SPI_RF_GEN2_TIMEOUT_EN
    logic [CNT_W-1:0] tout_q,     tout_d;
    logic [CNT_W-1:0] tout_cnt_q, tout_cnt_d;
    logic             tout_clr;
    logic             tout_hold;

    // Idle counter: counts while RX data sits unread, holds once it has fired.
    always_comb begin
        tout_d    = wr_tout ? pwdata[CNT_W-1:0] : tout_q;
        tout_clr  = rx_done | rx_fifo_read | rx_fifo_empty;
        tout_hold = (tout_q != '0) && (tout_cnt_q == tout_q);
        tout_set  = 1'b0;
        if (tout_clr) begin
            tout_cnt_d = '0;
        end else if (tout_hold) begin
            tout_cnt_d = tout_cnt_q;
        end else begin
            tout_cnt_d = tout_cnt_q + CNT_ONE;
            // Fire on the edge the count arrives at TOUT, exactly once.
            tout_set   = (tout_q != '0) && ((tout_cnt_q + CNT_ONE) == tout_q);
        end
    end

    // Timeout register and idle counter state.
    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            tout_q     <= '0;
            tout_cnt_q <= '0;
        end else if (!sresetn) begin
            tout_q     <= '0;
            tout_cnt_q <= '0;
        end else begin
            tout_q     <= tout_d;
            tout_cnt_q <= tout_cnt_d;
        end
    end
`else
    assign tout_set = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state for configuration, interrupts, frame counter and commands
    // -------------------------------------------------------------------------
    assign frmcnt_inc = frmcnt_q + CNT_ONE;
    assign frm_clr    = wr_cmd & pwdata[2];

    // Frame counter: a CMD clear beats rx_done; a threshold hit reloads 0.
    always_comb begin
        frmcnt_d = frmcnt_q;
        pkt_done = 1'b0;
        if (frm_clr) begin
            frmcnt_d = '0;
        end else if (rx_done && ctrl_q[0]) begin
            if ((frmthr_q != '0) && (frmcnt_inc == frmthr_q)) begin
                frmcnt_d = '0;
                pkt_done = 1'b1;
            end else begin
                frmcnt_d = frmcnt_inc;
            end
        end
    end

    // Interrupt latch: hardware sets are OR-ed in after the W1C, so they win.
    always_comb begin
        int_set   = {tout_set, pkt_done, tx_underflow, rx_overflow, rx_done, tx_done};
        int_clr   = wr_intclr ? pwdata[5:0] : 6'h00;
        int_raw_d = ((int_raw_q & ~int_clr) | int_set) & INT_IMPL;
    end

    // Software-writable registers and the one-cycle FIFO clear pulses.
    always_comb begin
        ctrl_d   = wr_ctrl   ? pwdata[1:0]          : ctrl_q;
        inten_d  = wr_inten  ? (pwdata[5:0] & INT_IMPL) : inten_q;
        frmthr_d = wr_frmthr ? pwdata[CNT_W-1:0]    : frmthr_q;
        ssel_d   = wr_ssel   ? pwdata[NUM_SSEL-1:0] : ssel_q;
        clr_rx_d = wr_cmd & pwdata[0];
        clr_tx_d = wr_cmd & pwdata[1];
    end

    // All register-file state; sresetn mirrors aresetn on the next edge.
    always_ff @(posedge pclk or negedge aresetn) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!aresetn) begin
            ctrl_q    <= '0;
            inten_q   <= '0;
            int_raw_q <= '0;
            frmthr_q  <= '0;
            frmcnt_q  <= '0;
            ssel_q    <= '0;
            clr_rx_q  <= 1'b0;
            clr_tx_q  <= 1'b0;
        end else if (!sresetn) begin
            ctrl_q    <= '0;
            inten_q   <= '0;
            int_raw_q <= '0;
            frmthr_q  <= '0;
            frmcnt_q  <= '0;
            ssel_q    <= '0;
            clr_rx_q  <= 1'b0;
            clr_tx_q  <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            inten_q   <= inten_d;
            int_raw_q <= int_raw_d;
            frmthr_q  <= frmthr_d;
            frmcnt_q  <= frmcnt_d;
            ssel_q    <= ssel_d;
            clr_rx_q  <= clr_rx_d;
            clr_tx_q  <= clr_tx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read mux, zero-extended to the bus width
    // -------------------------------------------------------------------------

    // Select the addressed register; write-only and unmapped slots read 0.
    always_comb begin
        rdata = '0;
        case (paddr)
            ADDR_CTRL:    rdata[1:0]          = ctrl_q;
            ADDR_INTEN:   rdata[5:0]          = inten_q;
            ADDR_INTMASK: rdata[5:0]          = int_raw_q & inten_q;
            ADDR_INTRAW:  rdata[5:0]          = int_raw_q;
            ADDR_FRMTHR:  rdata[CNT_W-1:0]    = frmthr_q;
            ADDR_STATUS:  rdata[2:0]          = {active, tx_fifo_full, rx_fifo_empty};
            ADDR_SSEL:    rdata[NUM_SSEL-1:0] = ssel_q;
            ADDR_FRMCNT:  rdata[CNT_W-1:0]    = frmcnt_q;
`ifdef SPI_RF_GEN2_TIMEOUT_EN
            ADDR_TOUT:    rdata[CNT_W-1:0]    = tout_q;
`endif
            default:      rdata = '0;
        endcase
    end

    assign prdata = rd_en ? rdata : '0;

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign interrupt  = |(int_raw_q & inten_q);
    assign cfg_enable = ctrl_q[0];
    assign cfg_master = ctrl_q[1];
    assign cfg_ssel   = ssel_q;
    assign clr_rxfifo = clr_rx_q;
    assign clr_txfifo = clr_tx_q;

    // Bits of the write bus beyond the widest field, and rx_fifo_read in the
    // build without the timeout, have no destination.
    logic unused_inputs;
    assign unused_inputs = ^{pwdata, rx_fifo_read, wr_tout};

endmodule

// File: doc/spi_rf_gen2.md
SPI_RF_GEN2 -- requirements
Module: spi_rf_gen2

Interface
REQ-001 SHALL provide parameter APB_DWIDTH, default 8, APB data width; legal values 8, 16, 32.
REQ-002 SHALL provide parameter NUM_SSEL, default 8, slave-select bit count; legal range 1..APB_DWIDTH.
REQ-003 SHALL provide parameter CNT_W, default 8, frame-counter and timeout width; legal range 4..APB_DWIDTH.
REQ-004 SHALL provide the following ports.
- pclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- sresetn  in  1  synchronous, active-low reset.
- paddr  in  7  APB byte address.
- psel, penable, pwrite  in  1 each  APB controls.
- pwdata  in  APB_DWIDTH  write data.
- prdata  out  APB_DWIDTH  read data.
- pslverr  out  1  unmapped-address error.
- interrupt  out  1  OR of masked interrupts.
- tx_done, rx_done  in  1 each  frame-complete strobes.
- rx_overflow, tx_underflow  in  1 each  error strobes.
- rx_fifo_read  in  1  RX FIFO pop strobe.
- rx_fifo_empty, tx_fifo_full  in  1 each  FIFO levels.
- active  in  1  SPI transfer in progress.
- cfg_enable, cfg_master  out  1 each  CTRL[0], CTRL[1].
- cfg_ssel  out  NUM_SSEL  slave-select register.
- clr_txfifo, clr_rxfifo  out  1 each  single-cycle clear pulses.

Function
REQ-005 SHALL decode a write when psel&pwrite&penable, and a read when psel&!pwrite&penable.
REQ-006 Register map; all registers zero-extended to APB_DWIDTH on read.
- 0x00 CTRL: RW bits [1:0].
- 0x04 INTCLR: W1C against int_raw; reads 0.
- 0x08 INTEN: RW bits [5:0].
- 0x10 INTMASK: RO, int_raw & INTEN.
- 0x14 INTRAW: RO bits [5:0].
- 0x18 FRMTHR: RW CNT_W bits.
- 0x1C CMD: write-only; reads 0.
- 0x20 STATUS: RO {active, tx_fifo_full, rx_fifo_empty}.
- 0x24 SSEL: RW NUM_SSEL bits.
- 0x28 FRMCNT: RO CNT_W bits.
- 0x2C TOUT: RW CNT_W bits.
REQ-007 prdata SHALL be 0 unless a read is decoded; prdata is combinational from paddr.
REQ-008 pslverr SHALL be 1 only in the access phase (psel&penable) to an unmapped address; the access has no effect.
REQ-009 int_raw bit assignment: [0] tx_done, [1] rx_done, [2] rx_overflow, [3] tx_underflow, [4] packet done, [5] RX timeout.
REQ-010 int_raw bits SHALL set one cycle after their event.
REQ-011 A hardware set SHALL win over a same-cycle INTCLR write to the same bit.
REQ-012 interrupt SHALL be registered-free, computed as |(int_raw & INTEN).
REQ-013 A write to CMD[0] or CMD[1] SHALL pulse clr_rxfifo or clr_txfifo, respectively, high for exactly one cycle after the write; both outputs are 0 otherwise.
REQ-014 FRMCNT SHALL increment on rx_done only while cfg_enable=1.
REQ-015 When FRMTHR!=0 and FRMCNT+1==FRMTHR, FRMCNT SHALL load 0 and int_raw[4] SHALL set in the same cycle.
REQ-016 When FRMTHR==0, FRMCNT SHALL free-run and wrap from 2^CNT_W-1 to 0 with no interrupt.
REQ-017 A write of 1 to CMD[2] SHALL clear FRMCNT to 0; this clear SHALL win over a same-cycle rx_done.
REQ-018 A write to FRMTHR SHALL NOT alter FRMCNT; if FRMCNT>=FRMTHR, counting SHALL continue through the wrap.
REQ-019 Writes to CTRL, SSEL, FRMTHR and TOUT SHALL take effect in the cycle after the write.

Reset
REQ-020 aresetn low SHALL asynchronously clear all registers, int_raw, FRMCNT, the timeout counter and all outputs to 0.
REQ-021 sresetn low SHALL have the same effect synchronously on the next pclk edge; reset mid-transfer SHALL discard pending pulses.

Configuration
REQ-022 Macro SPI_RF_GEN2_TIMEOUT_EN defined: TOUT, a CNT_W-bit idle counter and int_raw[5] SHALL be present.
- The counter increments per pclk while !rx_fifo_empty.
- It clears on rx_done, on rx_fifo_read, or when rx_fifo_empty=1.
- When TOUT!=0 and the counter reaches TOUT, int_raw[5] SHALL set once and the counter SHALL hold until its next clear.
REQ-023 Macro undefined: address 0x2C SHALL be unmapped (pslverr=1), and int_raw[5] and INTEN[5] SHALL read 0.

Verification
REQ-024 Write INTEN=0x01, pulse tx_done -> INTRAW=0x01, interrupt=1; write INTCLR=0x01 -> interrupt=0 next cycle.
REQ-025 CTRL=0x01, FRMTHR=3, three rx_done pulses -> FRMCNT sequence 1, 2, 0; int_raw[4]=1 after the third pulse.
REQ-026 FRMTHR=0, CNT_W=4, 17 rx_done pulses -> FRMCNT=1, int_raw[4]=0.
REQ-027 Same-cycle CMD[2] write and rx_done -> FRMCNT=0; same-cycle INTCLR=0x04 and rx_overflow -> int_raw[2]=1.
REQ-028 Read 0x30 -> pslverr=1, prdata=0; write CMD=0x03 -> clr_rxfifo and clr_txfifo each high for exactly 1 cycle.
REQ-029 With TIMEOUT_EN, TOUT=5, rx_fifo_empty=0 and idle -> int_raw[5] sets after 5 cycles; an rx_fifo_read at cycle 3 delays the set to cycle 8.
